// File: rtl/pipe_stage_regs.sv
// Y86-64 pipeline register bank: F, D, E, M and W stage registers driven by the
// hazard controller's stall/bubble commands, plus a sticky halted flag.
module pipe_stage_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        E_bubble,
  input  logic        M_bubble,
  input  logic        W_stall,
  input  logic [63:0] f_predPC,
  output logic [63:0] F_predPC,
  input  logic [3:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  input  logic [3:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [63:0] d_valA,
  input  logic [63:0] d_valB,
  output logic [3:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [63:0] E_valC,
  input  logic [3:0]  e_stat,
  input  logic [3:0]  e_icode,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  e_dstM,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] e_valA,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic [63:0] m_valE,
  input  logic [63:0] m_valM,
  output logic [3:0]  W_stat,
  output logic [3:0]  W_icode,
  output logic [3:0]  W_dstE,
  output logic [3:0]  W_dstM,
  output logic [63:0] W_valE,
  output logic [63:0] W_valM,
  output logic        halted
);

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef struct packed {
    logic [3:0]  stat, icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } d_reg_t;

  typedef struct packed {
    logic [3:0]  stat, icode, ifun, dste, dstm, srca, srcb;
    logic [63:0] vala, valb, valc;
  } e_reg_t;

  typedef struct packed {
    logic [3:0]  stat, icode, dste, dstm;
    logic        cnd;
    logic [63:0] vale, vala;
  } m_reg_t;

  typedef struct packed {
    logic [3:0]  stat, icode, dste, dstm;
    logic [63:0] vale, valm;
  } w_reg_t;

  // Bubble contents: an AOK nop with no register destinations.
  localparam d_reg_t D_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                               ra: R_NONE, rb: R_NONE, valc: 64'd0, valp: 64'd0};
  localparam e_reg_t E_NOP = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                               dste: R_NONE, dstm: R_NONE, srca: R_NONE, srcb: R_NONE,
                               vala: 64'd0, valb: 64'd0, valc: 64'd0};
  localparam m_reg_t M_NOP = '{stat: STAT_AOK, icode: I_NOP, dste: R_NONE, dstm: R_NONE,
                               cnd: 1'b0, vale: 64'd0, vala: 64'd0};
  localparam w_reg_t W_NOP = '{stat: STAT_AOK, icode: I_NOP, dste: R_NONE, dstm: R_NONE,
                               vale: 64'd0, valm: 64'd0};

  logic [63:0] f_pc_q, f_pc_d;
  d_reg_t      d_reg_q, d_reg_d;
  e_reg_t      e_reg_q, e_reg_d;
  m_reg_t      m_reg_q, m_reg_d;
  w_reg_t      w_reg_q, w_reg_d;
  logic        halted_q, halted_d;
  logic        w_load;

  always_comb begin
    f_pc_d = F_stall ? f_pc_q : f_predPC;

    if (D_bubble)     d_reg_d = D_NOP;
    else if (D_stall) d_reg_d = d_reg_q;
    else              d_reg_d = '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA,
                                  rb: f_rB, valc: f_valC, valp: f_valP};

    if (E_bubble) e_reg_d = E_NOP;
    else          e_reg_d = '{stat: d_stat, icode: d_icode, ifun: d_ifun, dste: d_dstE,
                              dstm: d_dstM, srca: d_srcA, srcb: d_srcB, vala: d_valA,
                              valb: d_valB, valc: d_reg_q.valc};

    if (M_bubble) m_reg_d = M_NOP;
    else          m_reg_d = '{stat: e_stat, icode: e_icode, dste: e_dstE, dstm: e_dstM,
                              cnd: e_cnd, vale: e_valE, vala: e_valA};

    // Once halted, W keeps the faulting instruction visible until reset.
    w_load   = !W_stall && !halted_q;
    w_reg_d  = w_reg_q;
    halted_d = halted_q;
    if (w_load) begin
      w_reg_d  = '{stat: m_stat, icode: m_icode, dste: m_dstE, dstm: m_dstM,
                   vale: m_valE, valm: m_valM};
      halted_d = (m_stat != STAT_AOK);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f_pc_q   <= 64'd0;
      d_reg_q  <= D_NOP;
      e_reg_q  <= E_NOP;
      m_reg_q  <= M_NOP;
      w_reg_q  <= W_NOP;
      halted_q <= 1'b0;
    end else begin
      f_pc_q   <= f_pc_d;
      d_reg_q  <= d_reg_d;
      e_reg_q  <= e_reg_d;
      m_reg_q  <= m_reg_d;
      w_reg_q  <= w_reg_d;
      halted_q <= halted_d;
    end
  end

  assign F_predPC = f_pc_q;
  assign D_stat   = d_reg_q.stat;
  assign D_icode  = d_reg_q.icode;
  assign D_ifun   = d_reg_q.ifun;
  assign D_rA     = d_reg_q.ra;
  assign D_rB     = d_reg_q.rb;
  assign D_valC   = d_reg_q.valc;
  assign D_valP   = d_reg_q.valp;
  assign E_stat   = e_reg_q.stat;
  assign E_icode  = e_reg_q.icode;
  assign E_ifun   = e_reg_q.ifun;
  assign E_dstE   = e_reg_q.dste;
  assign E_dstM   = e_reg_q.dstm;
  assign E_srcA   = e_reg_q.srca;
  assign E_srcB   = e_reg_q.srcb;
  assign E_valA   = e_reg_q.vala;
  assign E_valB   = e_reg_q.valb;
  assign E_valC   = e_reg_q.valc;
  assign M_stat   = m_reg_q.stat;
  assign M_icode  = m_reg_q.icode;
  assign M_dstE   = m_reg_q.dste;
  assign M_dstM   = m_reg_q.dstm;
  assign M_cnd    = m_reg_q.cnd;
  assign M_valE   = m_reg_q.vale;
  assign M_valA   = m_reg_q.vala;
  assign W_stat   = w_reg_q.stat;
  assign W_icode  = w_reg_q.icode;
  assign W_dstE   = w_reg_q.dste;
  assign W_dstM   = w_reg_q.dstm;
  assign W_valE   = w_reg_q.vale;
  assign W_valM   = w_reg_q.valm;
  assign halted   = halted_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Bench for pipe_stage_regs: directed hazard scenarios with literal expectations,
// then randomized commands/data checked every cycle against a stage-level model.
module tb_pipe_stage_regs;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;

  // clock/reset block
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
  logic [63:0] f_predPC, F_predPC;
  logic [3:0]  f_stat, f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
  logic [63:0] d_valA, d_valB;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
  logic        e_cnd;
  logic [63:0] e_valE, e_valA;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  m_stat, m_icode, m_dstE, m_dstM;
  logic [63:0] m_valE, m_valM;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic        halted;

  pipe_stage_regs dut (
    .clk(clk), .rst(rst),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .f_predPC(f_predPC), .F_predPC(F_predPC),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_dstE(d_dstE),
    .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_valA(d_valA), .d_valB(d_valB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_valA(E_valA),
    .E_valB(E_valB), .E_valC(E_valC),
    .e_stat(e_stat), .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM),
    .e_cnd(e_cnd), .e_valE(e_valE), .e_valA(e_valA),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
    .m_valE(m_valE), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  // Model: each stage is an array of field values, ordered as the outputs are.
  localparam int ND = 7, NE = 10, NM = 7, NW = 6;
  logic [63:0] mod_f;
  logic [63:0] mod_d[ND];
  logic [63:0] mod_e[NE];
  logic [63:0] mod_m[NM];
  logic [63:0] mod_w[NW];
  logic        mod_halted;

  function automatic void nop_stages();
    mod_d = '{AOK, 1, 0, 15, 15, 0, 0};
    mod_e = '{AOK, 1, 0, 15, 15, 15, 15, 0, 0, 0};
    mod_m = '{AOK, 1, 15, 15, 0, 0, 0};
    mod_w = '{AOK, 1, 15, 15, 0, 0};
  endfunction

  // Advance the model by one rising edge using the inputs now applied.
  function automatic void model_edge();
    logic [63:0] old_d_valc;
    old_d_valc = mod_d[5];
    if (rst) begin
      mod_f = 0;
      nop_stages();
      mod_halted = 0;
      return;
    end
    if (!F_stall) mod_f = f_predPC;
    if (D_bubble)      mod_d = '{AOK, 1, 0, 15, 15, 0, 0};
    else if (!D_stall) mod_d = '{f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
    if (E_bubble) mod_e = '{AOK, 1, 0, 15, 15, 15, 15, 0, 0, 0};
    else mod_e = '{d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB,
                   d_valA, d_valB, old_d_valc};
    if (M_bubble) mod_m = '{AOK, 1, 15, 15, 0, 0, 0};
    else mod_m = '{e_stat, e_icode, e_dstE, e_dstM, 64'(e_cnd), e_valE, e_valA};
    if (!W_stall && !mod_halted) begin
      mod_w = '{m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM};
      if (m_stat != AOK) mod_halted = 1;
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("F_predPC", F_predPC, mod_f);
    check("D_stat", D_stat, mod_d[0]);  check("D_icode", D_icode, mod_d[1]);
    check("D_ifun", D_ifun, mod_d[2]);  check("D_rA", D_rA, mod_d[3]);
    check("D_rB", D_rB, mod_d[4]);      check("D_valC", D_valC, mod_d[5]);
    check("D_valP", D_valP, mod_d[6]);
    check("E_stat", E_stat, mod_e[0]);  check("E_icode", E_icode, mod_e[1]);
    check("E_ifun", E_ifun, mod_e[2]);  check("E_dstE", E_dstE, mod_e[3]);
    check("E_dstM", E_dstM, mod_e[4]);  check("E_srcA", E_srcA, mod_e[5]);
    check("E_srcB", E_srcB, mod_e[6]);  check("E_valA", E_valA, mod_e[7]);
    check("E_valB", E_valB, mod_e[8]);  check("E_valC", E_valC, mod_e[9]);
    check("M_stat", M_stat, mod_m[0]);  check("M_icode", M_icode, mod_m[1]);
    check("M_dstE", M_dstE, mod_m[2]);  check("M_dstM", M_dstM, mod_m[3]);
    check("M_cnd", M_cnd, mod_m[4]);    check("M_valE", M_valE, mod_m[5]);
    check("M_valA", M_valA, mod_m[6]);
    check("W_stat", W_stat, mod_w[0]);  check("W_icode", W_icode, mod_w[1]);
    check("W_dstE", W_dstE, mod_w[2]);  check("W_dstM", W_dstM, mod_w[3]);
    check("W_valE", W_valE, mod_w[4]);  check("W_valM", W_valM, mod_w[5]);
    check("halted", halted, mod_halted);
  endtask

  // One edge: model follows the edge, every output is compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [3:0] rand_stat(input int fault_1_in);
    logic [3:0] s;
    s = AOK;
    if (fault_1_in > 0 && $urandom_range(fault_1_in - 1, 0) == 0)
      s = 4'b0001 << $urandom_range(2, 0);
    return s;
  endfunction

  // driver tasks
  task automatic drive_data(input int fault_1_in);
    f_predPC = {$urandom, $urandom};
    f_stat = rand_stat(fault_1_in); f_icode = 4'($urandom); f_ifun = 4'($urandom);
    f_rA = 4'($urandom); f_rB = 4'($urandom);
    f_valC = {$urandom, $urandom}; f_valP = {$urandom, $urandom};
    d_stat = rand_stat(fault_1_in); d_icode = 4'($urandom); d_ifun = 4'($urandom);
    d_dstE = 4'($urandom); d_dstM = 4'($urandom);
    d_srcA = 4'($urandom); d_srcB = 4'($urandom);
    d_valA = {$urandom, $urandom}; d_valB = {$urandom, $urandom};
    e_stat = rand_stat(fault_1_in); e_icode = 4'($urandom);
    e_dstE = 4'($urandom); e_dstM = 4'($urandom); e_cnd = 1'($urandom);
    e_valE = {$urandom, $urandom}; e_valA = {$urandom, $urandom};
    m_stat = rand_stat(fault_1_in); m_icode = 4'($urandom);
    m_dstE = 4'($urandom); m_dstM = 4'($urandom);
    m_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
  endtask

  task automatic drive_cmds(input logic fs, input logic ds, input logic db,
                            input logic eb, input logic mb, input logic ws);
    F_stall = fs; D_stall = ds; D_bubble = db; E_bubble = eb; M_bubble = mb; W_stall = ws;
  endtask

  initial begin
    rst = 1'b1;
    drive_cmds(0, 0, 0, 0, 0, 0);
    drive_data(0);
    mod_f = 0; mod_halted = 0; nop_stages();

    // Reset with random inputs: everything at the nop bubble.
    tick();
    check("rst_F_predPC", F_predPC, 64'h0);
    check("rst_D_icode", D_icode, 4'h1);
    check("rst_E_dstE", E_dstE, 4'hF);
    check("rst_M_stat", M_stat, 4'b1000);
    check("rst_W_icode", W_icode, 4'h1);
    check("rst_halted", halted, 1'b0);

    // Normal flow of an irmovq through the stages.
    rst = 1'b0;
    drive_data(0); f_icode = 4'h3; f_valC = 64'h10; f_stat = AOK;
    tick();
    check("flow_D_icode", D_icode, 4'h3);
    check("flow_D_valC", D_valC, 64'h10);
    drive_data(0); d_icode = 4'h3;
    tick();
    check("flow_E_icode", E_icode, 4'h3);
    check("flow_E_valC", E_valC, 64'h10);
    drive_data(0); e_icode = 4'h3;
    tick();
    check("flow_M_icode", M_icode, 4'h3);
    drive_data(0); m_icode = 4'h3;
    tick();
    check("flow_W_icode", W_icode, 4'h3);

    // Load/use: mrmovq in D is held while E gets a bubble.
    drive_data(0); f_icode = 4'h5; f_predPC = 64'h100;
    tick();
    check("lu_D_icode", D_icode, 4'h5);
    drive_data(0); f_icode = 4'h6; f_predPC = 64'h200;
    drive_cmds(1, 1, 0, 1, 0, 0);
    tick();
    check("lu_F_hold", F_predPC, 64'h100);
    check("lu_D_hold", D_icode, 4'h5);
    check("lu_E_icode", E_icode, 4'h1);
    check("lu_E_dstE", E_dstE, 4'hF);
    drive_data(0); d_icode = 4'h5; f_icode = 4'h6;
    drive_cmds(0, 0, 0, 0, 0, 0);
    tick();
    check("lu_E_load", E_icode, 4'h5);
    check("lu_D_next", D_icode, 4'h6);

    // Mispredict: D and E squashed, M loads normally.
    drive_data(0); e_icode = 4'h7; f_predPC = 64'h300;
    drive_cmds(0, 0, 1, 1, 0, 0);
    tick();
    check("mp_D_icode", D_icode, 4'h1);
    check("mp_E_icode", E_icode, 4'h1);
    check("mp_M_icode", M_icode, 4'h7);

    // Ret: fetch stalled, D bubbled, downstream advancing.
    for (int i = 0; i < 3; i++) begin
      drive_data(0); m_icode = 4'(4'hA + i);
      drive_cmds(1, 0, 1, 0, 0, 0);
      tick();
      check("ret_F_hold", F_predPC, 64'h300);
      check("ret_D_icode", D_icode, 4'h1);
      check("ret_W_icode", W_icode, 4'(4'hA + i));
    end

    // Halt: HLT retires into W, then W freezes despite W_stall=0.
    drive_data(0); m_stat = HLT; m_icode = 4'h0;
    drive_cmds(0, 0, 0, 0, 0, 0);
    tick();
    check("hlt_W_stat", W_stat, 4'b0100);
    check("hlt_halted", halted, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive_data(0); m_icode = 4'h9;
      tick();
      check("hlt_W_frozen", W_stat, 4'b0100);
      check("hlt_W_icode", W_icode, 4'h0);
    end
    rst = 1'b1; drive_cmds(1, 1, 0, 0, 0, 1);
    tick();
    check("hlt_rst_halted", halted, 1'b0);
    check("hlt_rst_W_stat", W_stat, 4'b1000);
    check("hlt_rst_F", F_predPC, 64'h0);

    // Randomized commands and data, occasional faults and resets.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(63, 0) == 0);
      drive_data(24);
      drive_cmds($urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0,
                 $urandom_range(5, 0) == 0, $urandom_range(5, 0) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
